// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CLA chunk per stage, carry registered
// between stages, global-stall valid/ready handshake, carry/overflow/zero flags and a tag.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = WIDTH / STAGES;
  localparam int NG = (CW + 3) / 4;
  localparam int L  = STAGES - 1;

  if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0 || (WIDTH / STAGES) < 4) begin : g_bad_params
    $error("cla_pipe_adder: illegal WIDTH/STAGES combination");
  end

  // One chunk: bit g/p, 4-bit group G/P, lookahead carry between groups. Returns {cout, sum}.
  function automatic logic [CW:0] cla_chunk(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                            input logic cin);
    logic [CW-1:0] g, p, s;
    logic          c, cc, gg, pp;
    g = a & b;
    p = a ^ b;
    s = '0;
    c = cin;
    for (int grp = 0; grp < NG; grp++) begin
      gg = 1'b0;
      pp = 1'b1;
      cc = c;
      for (int j = 0; j < 4; j++) begin
        if (grp * 4 + j < CW) begin
          s[grp*4+j] = p[grp*4+j] ^ cc;
          cc         = g[grp*4+j] | (p[grp*4+j] & cc);
          gg         = g[grp*4+j] | (p[grp*4+j] & gg);
          pp         = pp & p[grp*4+j];
        end
      end
      c = gg | (pp & c);
    end
    return {c, s};
  endfunction

  logic              w_adv;
  logic [WIDTH-1:0]  w_beff;
  logic              w_cin;
  logic [STAGES-1:0] r_vld;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_beff   = in_sub ? ~in_b : in_b;
  assign w_cin    = in_sub ? 1'b1 : in_cin;

  // Stage k holds the operand bits not yet consumed (chunks k..) and the result chunks below k.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * CW;
    logic [RW-1:0]         r_a;
    logic [RW-1:0]         r_b;
    logic                  r_c;
    logic [TAG_W-1:0]      r_tag;
    logic [CW:0]           w_ch;
    logic [(k+1)*CW-1:0]   w_res;

    assign w_ch = cla_chunk(r_a[CW-1:0], r_b[CW-1:0], r_c);

    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a   <= in_a;
          r_b   <= w_beff;
          r_c   <= w_cin;
          r_tag <= in_tag;
        end
      end
      assign w_res = w_ch[CW-1:0];
    end else begin : g_next
      logic [k*CW-1:0] r_s;
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a   <= g_st[k-1].r_a[RW+CW-1:CW];
          r_b   <= g_st[k-1].r_b[RW+CW-1:CW];
          r_c   <= g_st[k-1].w_ch[CW];
          r_s   <= g_st[k-1].w_res;
          r_tag <= g_st[k-1].r_tag;
        end
      end
      assign w_res = {w_ch[CW-1:0], r_s};
    end
  end

  logic [WIDTH-1:0] w_fsum;
  logic             w_fcout;
  logic             w_fovf;
  logic             w_fzero;

  // Output stage: flags from the completed sum and the top operand chunk's MSBs.
  assign w_fsum  = g_st[L].w_res;
  assign w_fcout = g_st[L].w_ch[CW];
  assign w_fovf  = (g_st[L].r_a[CW-1] == g_st[L].r_b[CW-1]) && (w_fsum[WIDTH-1] != g_st[L].r_a[CW-1]);
  assign w_fzero = (w_fsum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
      out_valid <= r_vld[L];
      if (r_vld[L]) begin
        out_sum  <= w_fsum;
        out_cout <= w_fcout;
        out_ovf  <= w_fovf;
        out_zero <= w_fzero;
        out_tag  <= g_st[L].r_tag;
      end
    end
  end

endmodule
